// File: rtl/width_packer.sv
`default_nettype none
// ============================================================================
// Module      : width_packer
// Description : Packs a stream of S_WIDTH-bit words into P_WIDTH-bit output
//               words. An output word is emitted when all slots are filled,
//               or when a word carries in_last (partial words are zero-padded).
//               Uses valid/ready handshakes on both sides and allows
//               back-to-back output words with no bubble.
// Revision    : 1.0 - initial release
// ============================================================================
module width_packer #(
    parameter int S_WIDTH   = 8,
    parameter int P_WIDTH   = 64,
    parameter int MSB_FIRST = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [S_WIDTH-1:0]                   in_data,
    input  logic                                 in_last,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [P_WIDTH-1:0]                   out_data,
    output logic [$clog2(P_WIDTH/S_WIDTH):0]     out_count
);

    localparam int COUNT_MAX = P_WIDTH / S_WIDTH;
    localparam int CNT_W     = $clog2(COUNT_MAX);
    localparam int OCNT_W    = CNT_W + 1;

    // Reject geometries where the slots do not tile the output word exactly.
    generate
        if (((P_WIDTH % S_WIDTH) != 0) || (COUNT_MAX < 2)) begin : g_bad_params
            $error("width_packer: P_WIDTH must be a multiple of S_WIDTH with at least two slots");
        end
    endgenerate

    // Lowest bit index of slot k in the packed word.
    function automatic int slot_lo(input int k);
        if (MSB_FIRST != 0) begin
            return P_WIDTH - (k + 1) * S_WIDTH;
        end else begin
            return k * S_WIDTH;
        end
    endfunction

    // Architectural state
    logic [P_WIDTH-1:0] asm_q,       asm_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [P_WIDTH-1:0] out_data_q,  out_data_d;
    logic [OCNT_W-1:0]  out_count_q, out_count_d;

    // Handshake and completion decode
    logic               accept;
    logic               complete;
    logic [P_WIDTH-1:0] asm_merged;

    assign in_ready = !rst && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign complete = accept && ((cnt_q == CNT_W'(COUNT_MAX - 1)) || in_last);

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;

    // Assembly register with the incoming word dropped into the current slot;
    // unfilled slots stay zero because the register is cleared per packet.
    always_comb begin
        asm_merged = asm_q;
        for (int k = 0; k < COUNT_MAX; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                asm_merged[slot_lo(k) +: S_WIDTH] = in_data;
            end
        end
    end

    // Next-state: completion loads the output (possibly replacing a word being
    // consumed this cycle); a plain consume clears the output register.
    always_comb begin
        asm_d       = asm_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;

        if (accept) begin
            if (complete) begin
                asm_d = '0;
                cnt_d = '0;
            end else begin
                asm_d = asm_merged;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        if (complete) begin
            out_valid_d = 1'b1;
            out_data_d  = asm_merged;
            out_count_d = OCNT_W'(cnt_q) + OCNT_W'(1);
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_count_d = '0;
        end
    end

    // State registers with synchronous reset discarding any partial packet.
    always_ff @(posedge clk) begin
        if (rst) begin
            asm_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
        end else begin
            asm_q       <= asm_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_width_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_width_packer
// Description : Self-checking bench for width_packer (8-bit into 64-bit).
//               Runs an MSB-first and an LSB-first instance in lockstep.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_width_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        out_ready;

    logic        m_in_ready, m_out_valid;
    logic [63:0] m_out_data;
    logic [3:0]  m_out_count;
    logic        l_in_ready, l_out_valid;
    logic [63:0] l_out_data;
    logic [3:0]  l_out_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    width_packer #(.S_WIDTH(8), .P_WIDTH(64), .MSB_FIRST(1)) dut_msb (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (m_in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (m_out_valid),
        .out_ready (out_ready),
        .out_data  (m_out_data),
        .out_count (m_out_count)
    );

    width_packer #(.S_WIDTH(8), .P_WIDTH(64), .MSB_FIRST(0)) dut_lsb (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (l_in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (l_out_valid),
        .out_ready (out_ready),
        .out_data  (l_out_data),
        .out_count (l_out_count)
    );

    typedef struct {
        logic        rst;
        logic        vld;
        logic [7:0]  data;
        logic        last;
        logic        ordy;
        logic        exp_rdy;
        logic        exp_ov;
        logic [63:0] exp_msb;
        logic [63:0] exp_lsb;
        logic [3:0]  exp_cnt;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic r, input logic v, input logic [7:0] d,
                                input logic l, input logic o, input logic er,
                                input logic eov, input logic [63:0] em,
                                input logic [63:0] el, input logic [3:0] ec);
        vec_t t;
        t.rst = r; t.vld = v; t.data = d; t.last = l; t.ordy = o;
        t.exp_rdy = er; t.exp_ov = eov; t.exp_msb = em; t.exp_lsb = el; t.exp_cnt = ec;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        int guard;
        logic r;
        int hits [2];
        int nhits;
        int lows;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;

        // ---------------- table-driven vectors ----------------
        vecs[0] = mk(1, 0, 8'h00, 0, 1, 0, 0, 64'h0, 64'h0, 4'd0);
        for (int k = 1; k <= 7; k++)
            vecs[k] = mk(0, 1, 8'(k), 0, 1, 1, 0, 64'h0, 64'h0, 4'd0);
        vecs[8]  = mk(0, 1, 8'h08, 0, 1, 1, 1, 64'h0102030405060708, 64'h0807060504030201, 4'd8);
        vecs[9]  = mk(0, 1, 8'hAA, 0, 1, 1, 0, 64'h0, 64'h0, 4'd0);
        vecs[10] = mk(0, 1, 8'hBB, 0, 1, 1, 0, 64'h0, 64'h0, 4'd0);
        vecs[11] = mk(0, 1, 8'hCC, 1, 1, 1, 1, 64'hAABBCC0000000000, 64'h0000000000CCBBAA, 4'd3);
        vecs[12] = mk(0, 1, 8'hDD, 1, 1, 1, 1, 64'hDD00000000000000, 64'h00000000000000DD, 4'd1);
        vecs[13] = mk(0, 0, 8'h00, 0, 0, 0, 1, 64'hDD00000000000000, 64'h00000000000000DD, 4'd1);
        vecs[14] = mk(0, 1, 8'h55, 0, 0, 0, 1, 64'hDD00000000000000, 64'h00000000000000DD, 4'd1);
        vecs[15] = mk(0, 0, 8'h00, 0, 1, 1, 0, 64'h0, 64'h0, 4'd0);
        vecs[16] = mk(0, 0, 8'h77, 1, 1, 1, 0, 64'h0, 64'h0, 4'd0);

        for (int i = 0; i < NVEC; i++) begin
            rst = vecs[i].rst; in_valid = vecs[i].vld; in_data = vecs[i].data;
            in_last = vecs[i].last; out_ready = vecs[i].ordy;
            #1;
            chk($sformatf("v%0d_in_ready", i), 64'(m_in_ready), 64'(vecs[i].exp_rdy));
            tick();
            chk($sformatf("v%0d_out_valid", i), 64'(m_out_valid), 64'(vecs[i].exp_ov));
            chk($sformatf("v%0d_msb_data", i), m_out_data, vecs[i].exp_msb);
            chk($sformatf("v%0d_lsb_data", i), l_out_data, vecs[i].exp_lsb);
            chk($sformatf("v%0d_out_count", i), 64'(m_out_count), 64'(vecs[i].exp_cnt));
        end

        // ---------------- backpressure: 16 words, out_ready low ----------------
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 12; c++) begin
            in_valid = 1'b1; in_data = 8'(acc + 1);
            #1; r = m_in_ready;
            tick();
            if (r) acc++;
        end
        chk("bp_accepts_stalled", 64'(acc), 64'd8);
        chk("bp_out_valid", 64'(m_out_valid), 64'd1);
        chk("bp_data_held", m_out_data, 64'h0102030405060708);
        chk("bp_in_ready_low", 64'(m_in_ready), 64'd0);
        out_ready = 1'b1;
        guard = 0;
        while (acc < 16 && guard < 40) begin
            in_valid = 1'b1; in_data = 8'(acc + 1);
            #1; r = m_in_ready;
            tick();
            if (r) acc++;
            guard++;
        end
        chk("bp_accepts_total", 64'(acc), 64'd16);
        chk("bp_second_valid", 64'(m_out_valid), 64'd1);
        chk("bp_second_data", m_out_data, 64'h090A0B0C0D0E0F10);
        chk("bp_second_count", 64'(m_out_count), 64'd8);
        in_valid = 1'b0;
        tick();
        chk("bp_drained", 64'(m_out_valid), 64'd0);

        // ---------------- reset mid-packet ----------------
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_data = 8'hE1 + 8'(k);
            tick();
        end
        rst = 1'b1; in_data = 8'hEE;
        #1;
        chk("rst_in_ready", 64'(m_in_ready), 64'd0);
        tick();
        chk("rst_out_valid", 64'(m_out_valid), 64'd0);
        chk("rst_out_data", m_out_data, 64'h0);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1; in_data = 8'h11 + 8'(k);
            tick();
        end
        in_valid = 1'b0;
        chk("rst_pkt_valid", 64'(m_out_valid), 64'd1);
        chk("rst_pkt_msb", m_out_data, 64'h1112131415161718);
        chk("rst_pkt_lsb", l_out_data, 64'h1817161514131211);
        chk("rst_pkt_count", 64'(m_out_count), 64'd8);
        tick();

        // ---------------- streaming throughput ----------------
        hits[0] = -1; hits[1] = -1; nhits = 0; lows = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            in_valid = (c < 16); in_data = 8'(c + 1);
            #1;
            if (in_valid && !m_in_ready) lows++;
            tick();
            if (m_out_valid) begin
                if (nhits < 2) hits[nhits] = c;
                nhits++;
            end
        end
        in_valid = 1'b0;
        chk("stream_pulses", 64'(nhits), 64'd2);
        chk("stream_first_pulse", 64'(hits[0]), 64'd7);
        chk("stream_spacing", 64'(hits[1] - hits[0]), 64'd8);
        chk("stream_ready_lows", 64'(lows), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/width_packer.md
WIDTH_PACKER -- requirements
Module: width_packer

Interface
REQ-001 SHALL have parameter S_WIDTH, default 8, input word width in bits.
REQ-002 SHALL have parameter P_WIDTH, default 64, packed output width in bits.
REQ-003 SHALL have parameter MSB_FIRST, default 1; 1 = first word in top slot, 0 = first word in bottom slot.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  upstream word present.
REQ-007 SHALL have port in_ready  output  1  block can accept a word this cycle.
REQ-008 SHALL have port in_data  input  S_WIDTH  input word.
REQ-009 SHALL have port in_last  input  1  accepted word closes the current packet and flushes a partial word.
REQ-010 SHALL have port out_valid  output  1  packed word available.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the packed word.
REQ-012 SHALL have port out_data  output  P_WIDTH  packed word.
REQ-013 SHALL have port out_count  output  $clog2(COUNT_MAX)+1  number of valid slots in out_data, range 1..COUNT_MAX.

Function
REQ-014 SHALL define COUNT_MAX = P_WIDTH/S_WIDTH and SHALL stop elaboration unless P_WIDTH is a multiple of S_WIDTH and COUNT_MAX >= 2.
REQ-015 SHALL accept a word only on a cycle with in_valid && in_ready (accept event).
REQ-016 SHALL drive in_ready = !rst && (!out_valid || out_ready), combinationally.
REQ-017 SHALL hold an assembly register and slot counter (0..COUNT_MAX-1); each accept writes in_data into slot k = counter and increments the counter.
REQ-018 SHALL map slot k to bits [P_WIDTH-1-k*S_WIDTH -: S_WIDTH] when MSB_FIRST=1, else to [k*S_WIDTH +: S_WIDTH].
REQ-019 SHALL complete a word on an accept where counter == COUNT_MAX-1 or in_last == 1.
REQ-020 On completion, SHALL load out_data with the assembled word including the current in_data, leave unfilled slots zero, set out_count = counter+1, set out_valid = 1 on the next edge, and clear the assembly register and counter to 0.
REQ-021 Latency SHALL be exactly one cycle from the completing accept edge to out_valid high; sustained throughput SHALL be one input word per cycle while out_ready is held high.
REQ-022 While out_valid && !out_ready, out_data and out_count SHALL remain stable and out_valid SHALL stay high.
REQ-023 On out_valid && out_ready without a simultaneous completion, out_valid SHALL fall on the next edge and out_data/out_count SHALL clear to 0.
REQ-024 On out_valid && out_ready simultaneous with a completion, the new word SHALL replace the old one with out_valid staying high (back-to-back, no bubble).
REQ-025 in_last on the COUNT_MAX-th word SHALL behave identically to a normal full completion; in_last with counter == 0 SHALL emit out_count = 1.
REQ-026 in_data, in_last SHALL be ignored on cycles without an accept.

Reset
REQ-027 While rst is high: out_valid = 0, out_data = 0, out_count = 0, in_ready = 0, assembly register and counter = 0.
REQ-028 Reset asserted mid-packet SHALL discard all partial data; the first accept after reset SHALL land in slot 0.

Verification (S_WIDTH=8, P_WIDTH=64, out_ready=1 unless stated)
REQ-029 MSB_FIRST=1, words 0x01..0x08 on 8 consecutive cycles -> one cycle after the 8th accept, out_valid=1, out_data=0x0102030405060708, out_count=8.
REQ-030 MSB_FIRST=0, same stimulus -> out_data=0x0807060504030201, out_count=8.
REQ-031 MSB_FIRST=1, 0xAA, 0xBB, 0xCC with in_last on 0xCC -> out_data=0xAABBCC0000000000, out_count=3; next packet starts in slot 0.
REQ-032 out_ready=0, 16 words offered continuously -> 8 accepted, out_valid high with 0x01..0x08 packed, in_ready low; after out_ready=1 for one cycle, accepts resume, second word 0x090A0B0C0D0E0F10 emitted.
REQ-033 5 words accepted, rst pulsed one cycle, then 0x11..0x18 -> out_data=0x1112131415161718, out_count=8, no residue from the first 5 words.
REQ-034 16 words streamed with out_ready=1 -> two out_valid pulses exactly 8 cycles apart, in_ready never low.
